// File: rtl/capture_pkg.sv
// Shared definitions for the input-capture peripheral: register map,
// control/status bit positions and the measurement state machine encoding.
package capture_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [2:0] CAP_CTRL     = 3'd0;
  localparam logic [2:0] CAP_STATUS   = 3'd1;
  localparam logic [2:0] CAP_SCALE_L  = 3'd2;
  localparam logic [2:0] CAP_SCALE_H  = 3'd3;
  localparam logic [2:0] CAP_PERIOD_L = 3'd4;
  localparam logic [2:0] CAP_PERIOD_H = 3'd5;
  localparam logic [2:0] CAP_HIGH_L   = 3'd6;
  localparam logic [2:0] CAP_HIGH_H   = 3'd7;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IE      = 2;

  // STATUS bit positions
  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_OVF  = 1;
  localparam int unsigned STAT_PIN  = 2;
  localparam int unsigned STAT_BUSY = 3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } cap_state_t;

  // Counter value after a measurement edge: a tick on that same cycle
  // already belongs to the new interval.
  function automatic logic [15:0] cnt_restart(input logic tick);
    return tick ? 16'd1 : 16'd0;
  endfunction

endpackage

// File: rtl/capture_sync.sv
// Multi-stage synchronizer for the asynchronous capture pin, followed by a
// previous-value flop that yields single-cycle rise/fall pulses.
module capture_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cap_pin,
  output logic pin_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchronizer chain, then remember the last level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~prev_q;
  assign fall  = ~pin_s & prev_q;

endmodule

// File: rtl/capture_unit.sv
// Memory-mapped input-capture peripheral: measures high time and period of
// cap_pin in prescaled ticks, with atomic 16-bit reads and a level irq.
module capture_unit
  import capture_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h08,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       cap_pin,
  output logic       irq
);

  cap_state_t  state_q;
  logic [2:0]  ctrl_q;
  logic [15:0] scale_q;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_run;
  logic [15:0] period_q, high_q;
  logic        done_q, ovf_q;
  logic [7:0]  per_sh_q, high_sh_q;
  logic [7:0]  dout_q;
  logic        irq_q;

  logic        pin_s, rise, fall;
  logic        tick, cnt_sat_tick;
  logic [7:0]  off;
  logic [2:0]  reg_sel;
  logic        in_win, wr_hit, rd_hit;
  logic        wr_ctrl, wr_stat;
  logic        en_wr, oneshot_fire, busy;

  capture_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_pin(cap_pin),
    .pin_s  (pin_s),
    .rise   (rise),
    .fall   (fall)
  );

  // Address decode: window is BASE_ADDR..BASE_ADDR+7
  assign off     = address - BASE_ADDR;
  assign in_win  = (off[7:3] == 5'd0);
  assign reg_sel = off[2:0];
  assign wr_hit  = w_en & in_win;
  assign rd_hit  = r_en & in_win;
  assign wr_ctrl = wr_hit && (reg_sel == CAP_CTRL);
  assign wr_stat = wr_hit && (reg_sel == CAP_STATUS);

  // EN as it will be after this edge, so a disabling write drops to IDLE
  // on the write edge itself rather than one cycle later.
  assign en_wr        = wr_ctrl ? din[CTRL_EN] : ctrl_q[CTRL_EN];
  assign oneshot_fire = en_wr && (state_q == LOW) && rise && ctrl_q[CTRL_ONESHOT];
  assign busy         = (state_q != IDLE);

  // Prescaler tick generation and saturating counter step
  always_comb begin
    tick         = (presc_q == scale_q);
    presc_d      = tick ? '0 : presc_q + 16'd1;
    cnt_sat_tick = tick && (cnt_q == CNT_MAX);
    cnt_run      = (tick && (cnt_q != CNT_MAX)) ? cnt_q + 16'd1 : cnt_q;
  end

  // Free-running prescaler; SCALE writes do not disturb its phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  // Writable configuration registers; hardware clears EN after a one-shot capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      scale_q <= '0;
    end else begin
      if (wr_ctrl) ctrl_q <= din[2:0];
      if (oneshot_fire) ctrl_q[CTRL_EN] <= 1'b0;
      if (wr_hit && (reg_sel == CAP_SCALE_L)) scale_q[7:0]  <= din;
      if (wr_hit && (reg_sel == CAP_SCALE_H)) scale_q[15:8] <= din;
    end
  end

  // Measurement FSM with counter, capture registers and sticky flags.
  // W1C clears are applied first so a same-edge set overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_stat && din[STAT_DONE]) done_q <= 1'b0;
      if (wr_stat && din[STAT_OVF])  ovf_q  <= 1'b0;
      if (!en_wr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt_q   <= cnt_restart(tick);
              state_q <= HIGH;
            end else begin
              cnt_q <= '0;
            end
          end
          HIGH: begin
            cnt_q <= cnt_run;
            if (cnt_sat_tick) ovf_q <= 1'b1;
            if (fall) begin
              high_q  <= cnt_q;
              state_q <= LOW;
            end
          end
          LOW: begin
            if (cnt_sat_tick) ovf_q <= 1'b1;
            if (rise) begin
              period_q <= cnt_q;
              done_q   <= 1'b1;
              if (ctrl_q[CTRL_ONESHOT]) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                state_q <= HIGH;
                cnt_q   <= cnt_restart(tick);
              end
            end else begin
              cnt_q <= cnt_run;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Registered read port; low-byte reads snapshot the matching high byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      per_sh_q  <= '0;
      high_sh_q <= '0;
    end else if (rd_hit) begin
      case (reg_sel)
        CAP_CTRL:    dout_q <= {5'd0, ctrl_q};
        CAP_STATUS:  dout_q <= {4'd0, busy, pin_s, ovf_q, done_q};
        CAP_SCALE_L: dout_q <= scale_q[7:0];
        CAP_SCALE_H: dout_q <= scale_q[15:8];
        CAP_PERIOD_L: begin
          dout_q   <= period_q[7:0];
          per_sh_q <= period_q[15:8];
        end
        CAP_PERIOD_H: dout_q <= per_sh_q;
        CAP_HIGH_L: begin
          dout_q    <= high_q[7:0];
          high_sh_q <= high_q[15:8];
        end
        CAP_HIGH_H:  dout_q <= high_sh_q;
        default:     dout_q <= dout_q;
      endcase
    end
  end

  // Level interrupt, registered from the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= ctrl_q[CTRL_IE] & (done_q | ovf_q);
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_capture_unit.sv
// Directed self-checking bench for capture_unit (BASE_ADDR = 8'h08).
module tb_capture_unit;

  localparam logic [7:0] A_CTRL     = 8'h08;
  localparam logic [7:0] A_STATUS   = 8'h09;
  localparam logic [7:0] A_SCALE_L  = 8'h0A;
  localparam logic [7:0] A_SCALE_H  = 8'h0B;
  localparam logic [7:0] A_PERIOD_L = 8'h0C;
  localparam logic [7:0] A_PERIOD_H = 8'h0D;
  localparam logic [7:0] A_HIGH_L   = 8'h0E;
  localparam logic [7:0] A_HIGH_H   = 8'h0F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       cap_pin;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  capture_unit #(
    .BASE_ADDR  (8'h08),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .address(address),
    .w_en   (w_en),
    .r_en   (r_en),
    .dout   (dout),
    .cap_pin(cap_pin),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    din     = d;
    w_en    = 1'b1;
    @(negedge clk);
    w_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    r_en    = 1'b1;
    @(negedge clk);
    r_en    = 1'b0;
    d       = dout;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic hold(input logic lvl, input int n);
    cap_pin = lvl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    address = '0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    cap_pin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", {8'h00, dout}, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("rst_ctrl",   A_CTRL,     8'h00);
    read_check("rst_status", A_STATUS,   8'h00);
    read_check("rst_scalel", A_SCALE_L,  8'h00);
    read_check("rst_perl",   A_PERIOD_L, 8'h00);
    read_check("rst_highh",  A_HIGH_H,   8'h00);

    // Basic measurement, SCALE=0: high 10, low 30
    bus_write(A_CTRL, 8'h05);
    hold(1'b1, 10);
    hold(1'b0, 30);
    hold(1'b1, 5);
    read_check("basic_status", A_STATUS,   8'h0D);
    check("basic_irq", {15'd0, irq}, 16'h0001);
    read_check("basic_perl",   A_PERIOD_L, 8'h28);
    read_check("basic_perh",   A_PERIOD_H, 8'h00);
    read_check("basic_highh",  A_HIGH_H,   8'h00);
    read_check("basic_highl",  A_HIGH_L,   8'h0A);
    read_check("oow_above",    8'h10,      8'h0A);
    read_check("oow_below",    8'h07,      8'h0A);
    hold(1'b0, 5);
    bus_write(A_STATUS, 8'h01);
    read_check("basic_clr_status", A_STATUS, 8'h08);
    check("basic_clr_irq", {15'd0, irq}, 16'h0000);
    bus_write(A_CTRL, 8'h00);

    // Overflow: high for 70000 clocks at SCALE=0
    bus_write(A_CTRL, 8'h05);
    hold(1'b1, 70000);
    hold(1'b0, 5);
    read_check("ovf_status", A_STATUS, 8'h0A);
    read_check("ovf_highl",  A_HIGH_L, 8'hFF);
    read_check("ovf_highh",  A_HIGH_H, 8'hFF);
    check("ovf_irq", {15'd0, irq}, 16'h0001);
    bus_write(A_CTRL, 8'h04);
    bus_write(A_STATUS, 8'h02);
    check("ovf_irq_hold", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    check("ovf_irq_drop", {15'd0, irq}, 16'h0000);
    read_check("ovf_clr_status", A_STATUS, 8'h00);

    // One-shot: high 12, low 20
    bus_write(A_CTRL, 8'h03);
    hold(1'b1, 12);
    hold(1'b0, 20);
    hold(1'b1, 5);
    read_check("os_status", A_STATUS,   8'h05);
    read_check("os_ctrl",   A_CTRL,     8'h02);
    read_check("os_perl",   A_PERIOD_L, 8'h20);
    read_check("os_highl",  A_HIGH_L,   8'h0C);
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 5);
    read_check("os_perl_kept", A_PERIOD_L, 8'h20);

    // Atomic read: PERIOD 0x01FF then 0x0200 between L and H reads
    bus_write(A_STATUS, 8'h01);
    hold(1'b0, 5);
    bus_write(A_CTRL, 8'h01);
    hold(1'b1, 100);
    hold(1'b0, 411);
    hold(1'b1, 5);
    read_check("atom_perl1", A_PERIOD_L, 8'hFF);
    hold(1'b1, 93);
    hold(1'b0, 412);
    hold(1'b1, 5);
    read_check("atom_perh_shadow", A_PERIOD_H, 8'h01);
    read_check("atom_perl2",       A_PERIOD_L, 8'h00);
    read_check("atom_perh2",       A_PERIOD_H, 8'h02);

    // Same-edge W1C of DONE and capture (high 11, period 31)
    hold(1'b0, 20);
    cap_pin = 1'b1;
    @(negedge clk);
    bus_write(A_STATUS, 8'h01);
    repeat (3) @(negedge clk);
    read_check("cont_status", A_STATUS,   8'h0D);
    read_check("cont_perl",   A_PERIOD_L, 8'h1F);
    read_check("cont_highl",  A_HIGH_L,   8'h0B);

    // Disable while in HIGH
    bus_write(A_CTRL, 8'h00);
    read_check("dis_status", A_STATUS,   8'h05);
    read_check("dis_perl",   A_PERIOD_L, 8'h1F);
    read_check("dis_perh",   A_PERIOD_H, 8'h00);
    read_check("dis_highl",  A_HIGH_L,   8'h0B);

    // Prescaled: SCALE=3, high 40, period 100
    hold(1'b0, 5);
    bus_write(A_SCALE_L, 8'h03);
    read_check("scale_l", A_SCALE_L, 8'h03);
    bus_write(A_CTRL, 8'h01);
    hold(1'b1, 40);
    hold(1'b0, 60);
    hold(1'b1, 5);
    read_check("ps_perl",  A_PERIOD_L, 8'h19);
    read_check("ps_perh",  A_PERIOD_H, 8'h00);
    read_check("ps_highl", A_HIGH_L,   8'h0A);

    // Asynchronous reset while in LOW
    bus_write(A_CTRL, 8'h05);
    hold(1'b0, 10);
    check("prerst_irq", {15'd0, irq}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", {8'h00, dout}, 16'h0000);
    check("async_rst_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_rst_ctrl",   A_CTRL,     8'h00);
    read_check("post_rst_status", A_STATUS,   8'h00);
    read_check("post_rst_perl",   A_PERIOD_L, 8'h00);
    read_check("post_rst_highl",  A_HIGH_L,   8'h00);
    read_check("post_rst_scalel", A_SCALE_L,  8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
